aes128_decrypt: RTL

Iterative AES-128 inverse cipher (FIPS-197 §5.3) that performs one round per clock. It is the receive-side counterpart to aes128_top: ciphertext produced by aes128_top under the same key must decrypt back to the original plaintext. A key-load phase first expands and stores all 11 round keys, after which any number of blocks can be decrypted against that key.

---
 rtl/aes_pkg.sv | 106 ++++++++++
 rtl/aes128_decrypt_if.sv | 23 ++
 rtl/aes_inv_round.sv | 17 +
 rtl/aes128_decrypt.sv | 136 +++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES tables, types and GF(2^8) helpers shared by the decrypt datapath
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic word_t sub_word(input word_t w);
        word_t o;
        for (int i = 0; i < 4; i++) o[31-8*i -: 8] = SBOX[w[31-8*i -: 8]];
        return o;
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Byte 4c+r is row r of column c; row r rotates right by r columns
    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic state_t inv_sub_bytes(input state_t s);
        state_t o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(8'h0e, a0) ^ gmul(8'h0b, a1) ^ gmul(8'h0d, a2) ^ gmul(8'h09, a3);
            o[119-32*c -: 8] = gmul(8'h09, a0) ^ gmul(8'h0e, a1) ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a3);
            o[111-32*c -: 8] = gmul(8'h0d, a0) ^ gmul(8'h09, a1) ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a3);
            o[103-32*c -: 8] = gmul(8'h0b, a0) ^ gmul(8'h0d, a1) ^ gmul(8'h09, a2) ^ gmul(8'h0e, a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes128_decrypt_if.sv
// rtl/aes128_decrypt_if.sv - key-load / block-decrypt handshake bundle
interface aes128_decrypt_if;
    import aes_pkg::*;

    logic   key_load;
    state_t key;
    logic   key_ready;
    logic   start;
    state_t ciphertext;
    state_t plaintext;
    logic   done;
    logic   busy;

    modport master (
        output key_load, key, start, ciphertext,
        input  key_ready, plaintext, done, busy
    );

    modport slave (
        input  key_load, key, start, ciphertext,
        output key_ready, plaintext, done, busy
    );
endinterface

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse-cipher round
module aes_inv_round
    import aes_pkg::*;
(
    input  state_t state_i,
    input  state_t round_key_i,
    input  logic   last_i,
    output state_t state_o
);
    state_t pre_mix;

    // Inverse round body; the final round skips InvMixColumns
    always_comb begin
        pre_mix = inv_sub_bytes(inv_shift_rows(state_i)) ^ round_key_i;
        state_o = last_i ? pre_mix : inv_mix_columns(pre_mix);
    end
endmodule

// File: rtl/aes128_decrypt.sv
// rtl/aes128_decrypt.sv - iterative AES-128 inverse cipher, one round per clock
module aes128_decrypt
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    aes128_decrypt_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_KEXP = 2'd1;
    localparam logic [1:0] ST_DEC  = 2'd2;
    localparam logic [3:0] RK_LAST = 4'(NR);

    state_t     rk_q [0:NR];
    logic [1:0] fsm_q, fsm_d;
    logic [3:0] round_q, round_d;
    state_t     st_q, st_d;
    state_t     pt_q, pt_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       kr_q, kr_d;
    logic       rk_we;
    logic [3:0] rk_widx;
    state_t     rk_wdata;
    state_t     rk_sel, rk_prev, rk_next, rnd_out;

    // Forward key schedule: derive round key round_q from round key round_q-1
    always_comb begin
        word_t w0, w1, w2, w3;
        rk_sel  = rk_q[round_q];
        rk_prev = rk_q[round_q - 4'd1];
        w0 = rk_prev[127:96] ^ sub_word(rot_word(rk_prev[31:0])) ^ {RCON[round_q], 24'h0};
        w1 = rk_prev[95:64] ^ w0;
        w2 = rk_prev[63:32] ^ w1;
        w3 = rk_prev[31:0]  ^ w2;
        rk_next = {w0, w1, w2, w3};
    end

    aes_inv_round u_round (
        .state_i     (st_q),
        .round_key_i (rk_sel),
        .last_i      (round_q == 4'd0),
        .state_o     (rnd_out)
    );

    // Control FSM: key_load has priority over start in IDLE; both ignored while busy
    always_comb begin
        fsm_d    = fsm_q;
        round_d  = round_q;
        st_d     = st_q;
        pt_d     = pt_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        kr_d     = kr_q;
        rk_we    = 1'b0;
        rk_widx  = round_q;
        rk_wdata = rk_next;
        case (fsm_q)
            ST_IDLE: begin
                if (bus.key_load) begin
                    rk_we    = 1'b1;
                    rk_widx  = 4'd0;
                    rk_wdata = bus.key;
                    round_d  = 4'd1;
                    kr_d     = 1'b0;
                    busy_d   = 1'b1;
                    fsm_d    = ST_KEXP;
                end else if (bus.start && kr_q) begin
                    st_d    = bus.ciphertext ^ rk_q[NR];
                    round_d = RK_LAST - 4'd1;
                    busy_d  = 1'b1;
                    fsm_d   = ST_DEC;
                end
            end
            ST_KEXP: begin
                rk_we = 1'b1;
                if (round_q == RK_LAST) begin
                    kr_d   = 1'b1;
                    busy_d = 1'b0;
                    fsm_d  = ST_IDLE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            ST_DEC: begin
                if (round_q == 4'd0) begin
                    pt_d   = rnd_out;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    fsm_d  = ST_IDLE;
                end else begin
                    st_d    = rnd_out;
                    round_d = round_q - 4'd1;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // Round-key storage, cleared on reset so a fresh key_load is required
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
        end else if (rk_we) begin
            rk_q[rk_widx] <= rk_wdata;
        end
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= ST_IDLE;
            round_q <= 4'd0;
            st_q    <= '0;
            pt_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            kr_q    <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            st_q    <= st_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            kr_q    <= kr_d;
        end
    end

    assign bus.key_ready = kr_q;
    assign bus.plaintext = pt_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
endmodule
